// File: rtl/dispensador_multi.sv
// Coin-operated vending controller: two synchronised coin inputs, saturating credit,
// automatic vend at PRICE, refund on cancel or idle timeout.
module dispensador_multi #(
    parameter int PRICE   = 3,
    parameter int VAL_A   = 1,
    parameter int VAL_B   = 2,
    parameter int CRED_W  = 4,
    parameter int PROD_W  = 5,
    parameter int TIMEOUT = 50_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              coin_a,
    input  logic              coin_b,
    input  logic              cancel,
    output logic [CRED_W-1:0] credit,
    output logic [CRED_W-1:0] change,
    output logic              vend,
    output logic              refund,
    output logic [PROD_W-1:0] products,
    output logic [1:0]        fsm_state
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int SW = CRED_W + 2;
    localparam logic [SW-1:0] CRED_MAX = SW'({CRED_W{1'b1}});

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        VEND   = 2'd2,
        RETURN = 2'd3
    } state_t;

    state_t state, state_next;

    logic [2:0]        a_sync, b_sync;
    logic [1:0]        fill;
    logic              armed_a, armed_b;
    logic              edge_a, edge_b;
    logic [TW-1:0]     timer, timer_next;
    logic [CRED_W-1:0] credit_next, change_next;
    logic [PROD_W-1:0] products_next;
    logic [SW-1:0]     coin_val;
    logic              coin_any;

    function automatic logic [CRED_W-1:0] sat(input logic [SW-1:0] v);
        return (v > CRED_MAX) ? {CRED_W{1'b1}} : v[CRED_W-1:0];
    endfunction

    // A level already high when the sync pipeline fills must go low before it can
    // count, so each channel is armed only after a valid low sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sync  <= '0;
            b_sync  <= '0;
            fill    <= '0;
            armed_a <= 1'b0;
            armed_b <= 1'b0;
            edge_a  <= 1'b0;
            edge_b  <= 1'b0;
        end else begin
            a_sync  <= {a_sync[1:0], coin_a};
            b_sync  <= {b_sync[1:0], coin_b};
            fill    <= {fill[0], 1'b1};
            armed_a <= armed_a | (fill[1] & ~a_sync[1]);
            armed_b <= armed_b | (fill[1] & ~b_sync[1]);
            edge_a  <= armed_a & a_sync[1] & ~a_sync[2];
            edge_b  <= armed_b & b_sync[1] & ~b_sync[2];
        end
    end

    always_comb begin
        coin_val = (edge_a ? SW'(VAL_A) : '0) + (edge_b ? SW'(VAL_B) : '0);
        coin_any = edge_a | edge_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            credit   <= '0;
            change   <= '0;
            products <= '0;
            timer    <= '0;
        end else begin
            state    <= state_next;
            credit   <= credit_next;
            change   <= change_next;
            products <= products_next;
            timer    <= timer_next;
        end
    end

    always_comb begin
        state_next    = state;
        credit_next   = credit;
        change_next   = change;
        products_next = products;
        timer_next    = '0;
        case (state)
            IDLE: begin
                if (coin_any) begin
                    credit_next = sat(coin_val);
                    if (credit_next != '0) state_next = ACCUM;
                end
            end
            ACCUM: begin
                // Coins are accepted before the decision so a cancel refunds them too.
                credit_next = sat(SW'(credit) + coin_val);
                timer_next  = coin_any ? '0 : timer + TW'(1);
                if (credit >= CRED_W'(PRICE))
                    state_next = VEND;
                else if (cancel || timer == TW'(TIMEOUT - 1))
                    state_next = RETURN;
                if (state_next != ACCUM) timer_next = '0;
            end
            VEND: begin
                change_next   = credit - CRED_W'(PRICE);
                products_next = (products == {PROD_W{1'b1}}) ? products : products + PROD_W'(1);
                credit_next   = sat(coin_val);
                state_next    = (credit_next != '0) ? ACCUM : IDLE;
            end
            RETURN: begin
                change_next = credit;
                credit_next = '0;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign vend      = (state == VEND);
    assign refund    = (state == RETURN);
    assign fsm_state = state;

endmodule

// File: tb/tb_dispensador_multi.sv
// Directed bench for dispensador_multi: stimulus pushes expected vend/refund outcomes,
// a monitor pops them whenever a pulse appears.
module tb_dispensador_multi;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       coin_a, coin_b, cancel;
    logic [3:0] credit, change;
    logic       vend, refund;
    logic [4:0] products;
    logic [1:0] fsm_state;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // {is_vend, change, products}
    logic [9:0] exp_q[$];

    dispensador_multi #(
        .PRICE(3), .VAL_A(1), .VAL_B(2), .CRED_W(4), .PROD_W(5), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .coin_a(coin_a), .coin_b(coin_b), .cancel(cancel),
        .credit(credit), .change(change), .vend(vend), .refund(refund),
        .products(products), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: every vend/refund pulse is matched against the next expected outcome.
    always @(negedge clk) begin
        logic       kind;
        logic [9:0] got, exp;
        if (rst_n && (vend || refund)) begin
            check("pulse_exclusive", int'(vend & refund), 0);
            kind = vend;
            @(posedge clk);
            #1;
            got = {kind, change, products};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got %h expected none", got);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL outcome: got kind=%0d change=%0d products=%0d expected kind=%0d change=%0d products=%0d",
                             got[9], got[8:5], got[4:0], exp[9], exp[8:5], exp[4:0]);
                end
            end
            check("pulse_width", int'(vend | refund), 0);
        end
    end

    // One coin pulse; credit is checked 3 edges after the edge that samples the rise.
    task automatic coin(input logic a, input logic b, input logic with_cancel,
                        input int exp_credit, output int t_upd);
        @(negedge clk);
        coin_a = a;
        coin_b = b;
        repeat (3) @(posedge clk);
        if (with_cancel) begin
            @(negedge clk);
            cancel = 1'b1;
        end
        @(posedge clk);
        #1;
        t_upd = cyc;
        check("credit_step", credit, exp_credit);
        @(negedge clk);
        coin_a = 1'b0;
        coin_b = 1'b0;
        cancel = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic settle_idle(input string name);
        repeat (3) @(posedge clk);
        #1;
        check({name, "_credit"}, credit, 0);
        check({name, "_state"}, fsm_state, 0);
    endtask

    initial begin
        int t0, dt, p;
        logic found;
        rst_n = 1'b0; coin_a = 1'b0; coin_b = 1'b0; cancel = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rst_credit", credit, 0);
        check("rst_change", change, 0);
        check("rst_products", products, 0);
        check("rst_state", fsm_state, 0);
        check("rst_pulses", int'(vend | refund), 0);

        // Three A coins: 1, 2, 3 then vend with no change.
        exp_q.push_back({1'b1, 4'd0, 5'd1});
        coin(1, 0, 0, 1, t0);
        coin(1, 0, 0, 2, t0);
        coin(1, 0, 0, 3, t0);
        settle_idle("aaa");

        // Two B coins: 2, 4 then vend with change 1.
        exp_q.push_back({1'b1, 4'd1, 5'd2});
        coin(0, 1, 0, 2, t0);
        coin(0, 1, 0, 4, t0);
        settle_idle("bb");

        // Simultaneous A and B.
        exp_q.push_back({1'b1, 4'd0, 5'd3});
        coin(1, 1, 0, 3, t0);
        settle_idle("ab");

        // Timeout refund 16 cycles after the credit update.
        exp_q.push_back({1'b0, 4'd2, 5'd3});
        coin(0, 1, 0, 2, t0);
        found = 1'b0;
        dt = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (refund) begin
                found = 1'b1;
                dt = cyc - t0;
            end
        end
        check("timeout_seen", int'(found), 1);
        check("timeout_delay", dt, 16);
        settle_idle("timeout");

        // Cancel in IDLE does nothing.
        @(negedge clk) cancel = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_cancel_state", fsm_state, 0);
        check("idle_cancel_pulse", int'(vend | refund), 0);
        @(negedge clk) cancel = 1'b0;

        // Cancel together with a second coin: refund includes that coin.
        exp_q.push_back({1'b0, 4'd2, 5'd3});
        coin(1, 0, 0, 1, t0);
        coin(1, 0, 1, 2, t0);
        settle_idle("cancel");

        // 32 more vends: product counter saturates at 31.
        p = 3;
        for (int i = 0; i < 32; i++) begin
            p = (p < 31) ? p + 1 : 31;
            exp_q.push_back({1'b1, 4'd0, 5'(p)});
            coin(1, 1, 0, 3, t0);
        end
        settle_idle("sat");
        check("sat_products", products, 31);

        exp_q.push_back({1'b1, 4'd1, 5'd31});
        coin(0, 1, 0, 2, t0);
        coin(0, 1, 0, 4, t0);
        settle_idle("pre_rst");
        check("pre_rst_change", change, 1);

        // Asynchronous reset mid-transaction.
        coin(0, 1, 0, 2, t0);
        check("pre_rst_queue", exp_q.size(), 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_credit", credit, 0);
        check("async_change", change, 0);
        check("async_products", products, 0);
        check("async_state", fsm_state, 0);
        check("async_pulses", int'(vend | refund), 0);

        // A coin level held high across reset release must not count.
        coin_a = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("held_coin_credit", credit, 0);
        check("held_coin_state", fsm_state, 0);
        @(negedge clk) coin_a = 1'b0;
        repeat (4) @(posedge clk);

        exp_q.push_back({1'b0, 4'd1, 5'd0});
        coin(1, 0, 0, 1, t0);
        @(negedge clk) cancel = 1'b1;
        @(negedge clk) cancel = 1'b0;
        settle_idle("post_rst");

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dispensador_multi.md
DISPENSADOR_MULTI -- requirements
Module: dispensador_multi

Interface
REQ-001 SHALL have parameter PRICE, default 3, product price in credit units (1 to 2^CRED_W-1).
REQ-002 SHALL have parameter VAL_A, default 1, credit value of coin type A.
REQ-003 SHALL have parameter VAL_B, default 2, credit value of coin type B.
REQ-004 SHALL have parameter CRED_W, default 4, width of credit/change.
REQ-005 SHALL have parameter PROD_W, default 5, width of product counter.
REQ-006 SHALL have parameter TIMEOUT, default 50_000_000, idle cycles before automatic refund (>=2).
REQ-007 SHALL have port clk, input, 1, single system clock (rising edge).
REQ-008 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-009 SHALL have port coin_a, input, 1, asynchronous level from the type-A coin sensor.
REQ-010 SHALL have port coin_b, input, 1, asynchronous level from the type-B coin sensor.
REQ-011 SHALL have port cancel, input, 1, synchronous user-cancel request, level-sampled each cycle.
REQ-012 SHALL have port credit, output, CRED_W, current accumulated credit.
REQ-013 SHALL have port change, output, CRED_W, change/refund amount of the last completed transaction, held.
REQ-014 SHALL have port vend, output, 1, one-cycle pulse, dispense one product.
REQ-015 SHALL have port refund, output, 1, one-cycle pulse, return credit without product.
REQ-016 SHALL have port products, output, PROD_W, total products dispensed since reset.

Function
REQ-017 SHALL synchronise coin_a and coin_b through two flops each, then detect rising edges against a third flop; each edge is one coin.
REQ-018 Coin pin rising before edge k SHALL update credit at edge k+3, with a 2-flop sync, an edge register, and a credit register.
REQ-019 Simultaneous A and B edges in one cycle SHALL both be counted: credit += VAL_A+VAL_B.
REQ-020 Credit addition SHALL saturate at 2^CRED_W-1 and never wrap.
REQ-021 SHALL implement FSM states IDLE (credit==0), ACCUM, VEND, RETURN.
REQ-022 IDLE->ACCUM on any coin edge; credit loads coin value.
REQ-023 ACCUM: when registered credit >= PRICE, next state VEND.
REQ-024 VEND (one cycle): vend=1, change<=credit-PRICE, products+=1 (saturating at 2^PROD_W-1), credit<=value of coins arriving this cycle (0 if none).
REQ-025 After VEND: ACCUM if new credit>0, else IDLE.
REQ-026 In ACCUM, an idle timer SHALL count cycles; it clears on each coin edge and on entry to ACCUM.
REQ-027 At timer==TIMEOUT-1, or cancel==1 while in ACCUM, next state SHALL be RETURN.
REQ-028 RETURN (one cycle): refund=1, change<=credit, credit<=0, products unchanged; then IDLE. Coins arriving in RETURN are lost.
REQ-029 Coin edge and cancel in the same ACCUM cycle: the coin SHALL be added first, and RETURN refunds the total.
REQ-030 Credit >= PRICE and cancel/timeout in the same cycle: VEND SHALL take priority.
REQ-031 Cancel in IDLE or VEND SHALL be ignored.
REQ-032 vend and refund SHALL never be high together, and each SHALL be high for exactly one cycle per event.
REQ-033 Leftover credit after VEND SHALL persist and may trigger further vends; it is not refunded automatically except by timeout or cancel.

Reset
REQ-034 rst_n low SHALL immediately and asynchronously force: state IDLE; credit, change, products, timer, and sync/edge flops to 0; vend=0, refund=0.
REQ-035 Reset mid-transaction SHALL discard credit without a refund pulse.
REQ-036 After rst_n rises, a coin level already high SHALL NOT count until it falls and rises again.

Verification (PRICE=3, VAL_A=1, VAL_B=2, CRED_W=4, PROD_W=5, TIMEOUT=16)
REQ-037 Three separate coin_a pulses -> credit 1,2,3, then one vend pulse, change=0, products=1, credit=0, state IDLE.
REQ-038 Two coin_b pulses -> credit 2,4, then vend, change=1, credit=0, products=1.
REQ-039 coin_a and coin_b rising on the same edge -> credit=3 in one step, then vend, change=0.
REQ-040 One coin_b, then no activity -> refund pulse 16 cycles after the credit update, change=2, credit=0, products unchanged.
REQ-041 One coin_a, then cancel=1 on the same cycle as a second coin_a edge -> refund, change=2; 32 vend transactions -> products saturates at 31.
REQ-042 Credit=2, then rst_n low mid-cycle -> credit, change, and products read 0 immediately, with no vend or refund pulse.
